intr_prio_ctrl: RTL
===================

// Module: intr_prio_ctrl
// PURPOSE
//  Parametrised interrupt prioritiser/poster for the PPC core; next generation of the fixed 8-source encoder.
//  Takes NUM_SRC request lines, each configurable as level or edge-latched and as maskable by MSR[EE] or not.
//  Fixed priority: index 0 is highest.
//  Posts one exception code, holds it until the core acks, returns a one-hot ack, then waits HOLDOFF cycles.
//  Sits between the exception sources (pipeline stages, TLBs, devices) and the interrupt register file / entry logic.
// PARAMETERS
//  NUM_SRC   16       number of request sources (1..31)
//  CODE_W    5        code width; requires 2**CODE_W > NUM_SRC
//  MASKABLE  16'hC000 bit i=1: source i is gated by ee (external/device sources)
//  EDGE_SRC  16'hC000 bit i=1: source i latched on rising edge; 0: level-sensitive
//  HOLDOFF   1        idle cycles after ack before re-arbitration (0..15)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous active-high reset
//  req        in   NUM_SRC  request lines, bit i = source i
//  ee         in   1        MSR[EE]; enables MASKABLE sources
//  clr_pend   in   NUM_SRC  software clear of latched edge pendings
//  ack        in   1        core has taken the posted exception
//  excepCode  out  CODE_W   posted code: 0 = NONE, else winning index+1
//  valid      out  1        excepCode != 0
//  ack_vec    out  NUM_SRC  one-hot ack to the served source
//  pend       out  NUM_SRC  latched edge pendings (status)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, excepCode=0, valid=0, pend=0, holdoff count=0.
//   req_d<=req during reset, so a line already high at reset release is not an edge.
//   ack_vec=0 while state!=POSTED.
//  Edge detect: edge[i]=req[i]&~req_d[i], with req_d registered every cycle.
//   pend[i] next = edge[i] | (pend[i] & ~clr_pend[i] & ~ack_vec[i]).
//   A new edge beats a same-cycle clear. Level sources never set pend.
//  Effective request: eff[i] = EDGE_SRC[i] ? (pend[i]|edge[i]) : req[i].
//  Eligibility: elig[i] = eff[i] & (~MASKABLE[i] | ee).
//  FSM (one state register, 3 states):
//   IDLE: if |elig, latch excepCode=lowest i with elig[i], plus 1, and go POSTED (1-cycle latency req->valid).
//         Else stay.
//   POSTED: excepCode frozen; req, ee and clr_pend changes do not alter it.
//         ack_vec = ack ? onehot(excepCode-1) : 0, combinational from the registered code.
//         On ack: excepCode<=0, then go HOLD if HOLDOFF>0, else IDLE.
//         A level source must drop req itself; an edge source's pend is cleared by ack_vec.
//   HOLD: count HOLDOFF cycles with excepCode=0 and ack ignored, then go IDLE.
//  ack outside POSTED has no effect.
//  clr_pend on the posted source does not withdraw a posted code.
//  Simultaneous requests: lowest index wins; losers stay pending (edge) or asserted (level) and are served after HOLD.
//  ee low at IDLE: MASKABLE sources are ignored but keep their pend; they are served when ee rises.
//  rst in any state returns to IDLE at that edge; a posted code is lost and pend is cleared.
// TESTING
//  1. Defaults; req[3] level high in IDLE -> next cycle excepCode=4, valid=1.
//     ack=1 -> ack_vec=16'h0008 that cycle; excepCode=0 next; re-posts 4 after 1 HOLD cycle if req[3] still high.
//  2. req[14] one-cycle pulse, ee=0 -> pend[14]=1, valid stays 0.
//     ee=1 -> next cycle excepCode=15; ack -> pend[14]=0.
//  3. req=16'h4006 same cycle, ee=1 -> excepCode=2.
//     After ack+HOLD: 3 (req[2] still high), then 15 (pend[14]).
//  4. Posted code 15, then req[0] rises -> excepCode stays 15 until ack, then 1 after HOLD.
//  5. clr_pend[15] and a req[15] edge in the same cycle -> pend[15]=1.
//     clr_pend[15] alone while idle, ee=0 -> pend[15]=0, never posted.
//  6. rst while POSTED code 5 -> next cycle excepCode=0, pend=0, ack_vec=0; req held high through reset gives no edge pend.

Source files
------------

// File: rtl/intr_prio_ctrl.sv
// Fixed-priority interrupt prioritiser/poster. Index 0 wins. Each source is
// level- or edge-latched, and may be gated by MSR[EE]. A posted code stays
// frozen until the core acks it. The served source then gets a one-hot ack,
// and the block idles for HOLDOFF cycles before it arbitrates again.
module intr_prio_ctrl #(
    parameter int unsigned         NUM_SRC  = 16,
    parameter int unsigned         CODE_W   = 5,
    parameter logic [NUM_SRC-1:0]  MASKABLE = NUM_SRC'('hC000),
    parameter logic [NUM_SRC-1:0]  EDGE_SRC = NUM_SRC'('hC000),
    parameter int unsigned         HOLDOFF  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  req,
    input  logic                ee,
    input  logic [NUM_SRC-1:0]  clr_pend,
    input  logic                ack,
    output logic [CODE_W-1:0]   excepCode,
    output logic                valid,
    output logic [NUM_SRC-1:0]  ack_vec,
    output logic [NUM_SRC-1:0]  pend
);

    localparam int unsigned HOLD_W = 4;
    localparam logic [HOLD_W:0] HOLD_END = (HOLD_W+1)'(HOLDOFF);

    typedef enum logic [1:0] {IDLE, POSTED, HOLD} state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_SRC-1:0]  req_d;
    logic [NUM_SRC-1:0]  edge_v;
    logic [NUM_SRC-1:0]  eff;
    logic [NUM_SRC-1:0]  elig;
    logic [NUM_SRC-1:0]  pend_nxt;
    logic [CODE_W-1:0]   win_code;
    logic                hold_done;

    // Edge detection, eligibility, lowest-index winner and pending update.
    always_comb begin
        edge_v   = req & ~req_d;
        eff      = (EDGE_SRC & (pend | edge_v)) | (~EDGE_SRC & req);
        elig     = eff & (~MASKABLE | {NUM_SRC{ee}});
        pend_nxt = EDGE_SRC & (edge_v | (pend & ~clr_pend & ~ack_vec));
        win_code = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_code = CODE_W'(i + 1);
            end
        end
        hold_done = (({1'b0, hold_cnt} + (HOLD_W+1)'(1)) >= HOLD_END);
    end

    // One-hot ack to the served source, only while a code is posted.
    always_comb begin
        ack_vec = '0;
        if (state == POSTED && ack) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                ack_vec[i] = (excepCode == CODE_W'(i + 1));
            end
        end
    end

    // Poster FSM together with its registered code, valid, pendings and req history.
    always_ff @(posedge clk) begin
        req_d <= req;
        if (rst) begin
            state     <= IDLE;
            excepCode <= '0;
            valid     <= 1'b0;
            hold_cnt  <= '0;
            pend      <= '0;
        end else begin
            pend <= pend_nxt;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        excepCode <= win_code;
                        valid     <= 1'b1;
                        state     <= POSTED;
                    end
                end
                POSTED: begin
                    if (ack) begin
                        excepCode <= '0;
                        valid     <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= (HOLDOFF > 0) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    excepCode <= '0;
                    valid     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
